rnd_sched: RTL and testbench
============================

Name: rnd_sched

Overview:
- Round-robin scheduler sharing one `rept` rounding-compression unit between two requesters: port 0 is the adder path and port 1 is the multiplier path.
- Accepts 128-bit pre-round significands (`fn`) with a precision flag (`db`) over valid/ready handshakes.
- Runs each winner through a 2-stage pipeline: input register, then `rept`, then output register.
- Returns the 55-bit `f1` tagged with requester id and sequence tag to the FPU rounder back end.

Parameters:
- NREQ, 2, number of requesters (fixed at 2 in this revision; arbitration logic written for NREQ).
- TAGW, 4, width of per-request sequence tag passed through unchanged.
- MAXOUT, 2, max in-flight requests per requester (pipeline occupancy credit limit).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline kill; drops all in-flight entries.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_fn  in  NREQ*128  packed significands, requester i at [128*i +: 128].
- req_db  in  NREQ  precision flag per requester (1 = double).
- req_tag  in  NREQ*TAGW  sequence tags.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_f1  out  55  `rept` result for the issued `fn`/`db`.
- out_id  out  1  requester index of result.
- out_tag  out  TAGW  tag of result.
- busy  out  1  any pipeline stage valid.

Behaviour:
- Reset: the following outputs and state take these values while `rst` is high and on the first cycle after it:
  - `req_ready` = 0, `out_valid` = 0, `out_f1` = 0, `out_id` = 0, `out_tag` = 0, `busy` = 0.
  - Round-robin pointer = 0, so requester 0 has priority first.
  - Credit counters = 0.
- Reset mid-operation discards all entries; nothing is emitted afterwards.
- Handshake: a transfer occurs when valid && ready in the same cycle. `req_ready` is combinational from pointer, credits, `req_valid` and stage-1 availability.
- `req_ready[i]` is asserted only for the single granted requester.
- Arbitration:
  - Eligible(i) = `req_valid[i]` && credit[i] < MAXOUT.
  - Grant goes to the first eligible requester at or after the pointer.
  - After any accepted grant, pointer = winner+1 mod NREQ. With no grant, the pointer holds.
- Stage-1 availability: S1 is free if empty or if S1 advances this cycle.
  - S1 advances when S2 is empty or S2 drains (`out_valid` && `out_ready`).
  - The pipeline is fully back-to-back: throughput 1/cycle when `out_ready` stays high.
- Pipeline:
  - S1 registers `fn`, `db`, id and tag.
  - `rept` is combinational on the S1 registers.
  - S2 registers `f1`, id and tag, and drives the `out_*` ports.
- Latency: accept at cycle N gives `out_valid` at cycle N+2 when not stalled.
- Backpressure: with `out_ready` = 0, S2 holds and all `out_*` are stable. S1 holds if full; `req_ready` deasserts once S1 is full.
- Credits:
  - credit[id] increments on accept and decrements on output drain.
  - Simultaneous accept and drain for the same id leaves it unchanged.
  - The counter never exceeds MAXOUT and never underflows; underflow is an assertion failure.
- flush:
  - Clears S1/S2 valid and all credits on the next edge; the pointer is kept.
  - `req_ready` = 0 during the flush cycle, so no accept happens then.
  - A flush coinciding with a drain still clears: the drain handshake completes and its credit is discarded.
- Ordering: results return in acceptance order (strict FIFO pipeline).
- `busy` = S1.valid | S2.valid.

Decomposition:
- Package `rnd_pkg`:
  - FN_W=128, F1_W=55 constants.
  - struct `rnd_req_t` {fn, db, id, tag}.
  - struct `rnd_res_t` {f1, id, tag}.
- One sub-module: `rnd_rr_arb` (NREQ-way round-robin grant with pointer update).
- The existing `rept` is instantiated as the shared datapath.

Test Plan:
- Single request: req0 `fn`=128'hA1B2C3D4E5F60789ABCDEF0123456789, `db`=1, tag=3 → `out_valid` exactly 2 cycles later, `out_f1` = `rept` model value, `out_id`=0, `out_tag`=3, `busy` high for 2 cycles.
- Contention: both valid every cycle, `out_ready`=1 → grants alternate 0,1,0,1. `out_id` sequence is 0,1,0,1 at 1 result/cycle, tags preserved per id.
- Backpressure: `out_ready`=0 for 5 cycles with req0 streaming → at most 2 accepts, S2 outputs stable, `req_ready`=0 afterwards. Releasing `out_ready` resumes in order with no loss or duplicate.
- Credit limit: MAXOUT=2 with `out_ready` held low and only req1 valid → req1 accepted twice then `req_ready[1]`=0. A simultaneous req0 arriving afterwards gets no grant while the pipeline is full.
- flush with 2 entries in flight → next cycle `out_valid`=0, `busy`=0, credits 0. A new req0 with `fn`=128'h1234567890ABCDEFFEDCBA0987654321, `db`=0 returns after 2 cycles.
- Reset asserted while S2 holds a result with `out_ready`=0 → `out_valid`=0 the cycle after, pointer=0. First post-reset contention grants req0.

Source files
------------

// File: rtl/rnd_pkg.sv
// Shared types and widths for the rounding-compression scheduler.
package rnd_pkg;
  localparam int FN_W  = 128;
  localparam int F1_W  = 55;
  localparam int TAG_W = 4;
  localparam int ID_W  = 1;

  typedef struct packed {
    logic [FN_W-1:0]  fn;
    logic             db;
    logic [ID_W-1:0]  id;
    logic [TAG_W-1:0] tag;
  } rnd_req_t;

  typedef struct packed {
    logic [F1_W-1:0]  f1;
    logic [ID_W-1:0]  id;
    logic [TAG_W-1:0] tag;
  } rnd_res_t;
endpackage

// File: rtl/rept.sv
// Pre-round compression: keep the leading significand bits for the selected
// precision and fold everything below into a single sticky bit.
module rept (
  input  logic [127:0] fn,
  input  logic         db,
  output logic [54:0]  f1
);
  always_comb begin
    if (db) f1 = {fn[127:74], |fn[73:0]};
    else    f1 = {fn[127:103], |fn[102:0], 29'd0};
  end
endmodule

// File: rtl/rnd_rr_arb.sv
// NREQ-way round-robin grant; pointer moves past the winner on every grant.
module rnd_rr_arb #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr, ptr_nxt;
  logic          found;
  int            idx;

  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    if (en) begin
      for (int off = 0; off < NREQ; off++) begin
        idx = (int'(ptr) + off) % NREQ;
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          ptr_nxt  = PW'((idx + 1) % NREQ);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else     ptr <= ptr_nxt;
  end
endmodule

// File: rtl/rnd_sched.sv
// Round-robin scheduler sharing one rept unit between the adder and multiplier
// paths through a 2-stage stallable pipeline (S1 input reg, S2 result reg).
module rnd_sched
  import rnd_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int TAGW   = TAG_W,
  parameter int MAXOUT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*FN_W-1:0] req_fn,
  input  logic [NREQ-1:0]      req_db,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [F1_W-1:0]      out_f1,
  output logic                 out_id,
  output logic [TAGW-1:0]      out_tag,
  output logic                 busy
);
  localparam int STAGES = 2;
  localparam int CW     = $clog2(MAXOUT + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAXOUT);

  logic [STAGES:1]          vld_pipe;
  rnd_req_t                 s1, sel;
  rnd_res_t                 s2;
  logic [F1_W-1:0]          f1;
  logic [NREQ-1:0]          elig, gnt;
  logic [NREQ-1:0][CW-1:0]  credit;
  logic                     drain, s2_take, s1_free, arb_en, accept;

  assign drain   = vld_pipe[2] & out_ready;
  assign s2_take = !vld_pipe[2] | out_ready;
  assign s1_free = !vld_pipe[1] | s2_take;
  assign arb_en  = s1_free & !flush & !rst;
  assign accept  = |gnt;

  for (genvar i = 0; i < NREQ; i++) begin : g_elig
    assign elig[i] = req_valid[i] && (credit[i] < MAXC);
  end

  rnd_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req (elig),
    .gnt (gnt)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel.fn  = req_fn[FN_W*i +: FN_W];
        sel.db  = req_db[i];
        sel.id  = ID_W'(i);
        sel.tag = req_tag[TAGW*i +: TAGW];
      end
    end
  end

  rept u_rept (
    .fn (s1.fn),
    .db (s1.db),
    .f1 (f1)
  );

  // A drain coinciding with flush still completes downstream; its credit is
  // simply wiped along with the rest.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      credit <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] && !(drain && s2.id == ID_W'(i)))
          credit[i] <= credit[i] + 1'b1;
        else if (!gnt[i] && drain && s2.id == ID_W'(i))
          credit[i] <= credit[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      if (flush) begin
        vld_pipe <= '0;
      end else begin
        if (s2_take) vld_pipe[2] <= vld_pipe[1];
        if (accept)       vld_pipe[1] <= 1'b1;
        else if (s2_take) vld_pipe[1] <= 1'b0;
      end
      if (accept) s1 <= sel;
      if (s2_take && vld_pipe[1]) s2 <= '{f1: f1, id: s1.id, tag: s1.tag};
    end
  end

  assign req_ready = gnt;
  assign out_valid = vld_pipe[2];
  assign out_f1    = s2.f1;
  assign out_id    = s2.id;
  assign out_tag   = s2.tag;
  assign busy      = |vld_pipe;

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    drain |-> credit[s2.id] != '0);
endmodule

// File: tb/tb_rnd_sched.sv
// Randomized bench for rnd_sched against a transaction-level queue model.
module tb_rnd_sched;
  logic         clk = 1'b0;
  logic         rst, flush, out_ready;
  logic [1:0]   req_valid, req_ready, req_db;
  logic [255:0] req_fn;
  logic [7:0]   req_tag;
  logic         out_valid, out_id, busy;
  logic [54:0]  out_f1;
  logic [3:0]   out_tag;

  always #5 clk = ~clk;

  rnd_sched dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fn(req_fn), .req_db(req_db), .req_tag(req_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_f1(out_f1), .out_id(out_id), .out_tag(out_tag), .busy(busy)
  );

  int errors = 0, checks = 0;

  // Model: in-flight results in acceptance order, each with cycles since accept.
  typedef struct {
    logic [54:0] f1;
    int          id;
    logic [3:0]  tag;
    int          age;
  } ent_t;
  ent_t q[$];
  int   ptr = 0;
  int   cred[2] = '{0, 0};
  int   m_win;

  function automatic logic [54:0] ref_rept(logic [127:0] fn, logic db);
    logic [127:0] hi;
    logic         st;
    if (db) begin
      hi = fn >> 74;
      st = (fn << 54) != 0;
      return {hi[53:0], st};
    end
    hi = fn >> 103;
    st = (fn << 25) != 0;
    return {hi[24:0], st, 29'd0};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_req(int i, logic v, logic [127:0] fn, logic db, logic [3:0] tag);
    req_valid[i]         = v;
    req_fn[128*i +: 128] = fn;
    req_db[i]            = db;
    req_tag[4*i +: 4]    = tag;
  endtask

  // One clock: compare DUT against model, clock, then advance the model.
  task automatic step();
    logic       exp_ov, drn;
    logic [1:0] exp_rdy;
    bit         free;
    int         idx;
    ent_t       e;
    #1;
    exp_ov = q.size() > 0 && q[0].age >= 2;
    drn    = exp_ov && out_ready;
    free   = q.size() < 2 || drn;
    m_win  = -1;
    if (!rst && !flush && free)
      for (int off = 0; off < 2; off++) begin
        idx = (ptr + off) % 2;
        if (m_win < 0 && req_valid[idx] && cred[idx] < 2) m_win = idx;
      end
    exp_rdy = (m_win < 0) ? 2'b00 : 2'(1 << m_win);
    checks++;
    if (req_ready !== exp_rdy) begin
      errors++; $display("FAIL req_ready: got %b want %b", req_ready, exp_rdy);
    end
    checks++;
    if (out_valid !== exp_ov) begin
      errors++; $display("FAIL out_valid: got %b want %b", out_valid, exp_ov);
    end
    checks++;
    if (busy !== 1'(q.size() > 0)) begin
      errors++; $display("FAIL busy: got %b want %b", busy, q.size() > 0);
    end
    if (exp_ov) begin
      checks++;
      if (out_f1 !== q[0].f1 || out_id !== 1'(q[0].id) || out_tag !== q[0].tag) begin
        errors++;
        $display("FAIL result: got f1=%h id=%0d tag=%0d want f1=%h id=%0d tag=%0d",
                 out_f1, out_id, out_tag, q[0].f1, q[0].id, q[0].tag);
      end
    end
    if (m_win >= 0) begin
      e.f1  = ref_rept(req_fn[128*m_win +: 128], req_db[m_win]);
      e.id  = m_win;
      e.tag = req_tag[4*m_win +: 4];
      e.age = 1;
    end
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
      cred = '{0, 0};
      if (rst) ptr = 0;
    end else begin
      if (drn) begin
        cred[q[0].id]--;
        void'(q.pop_front());
      end
      foreach (q[k]) q[k].age++;
      if (m_win >= 0) begin
        q.push_back(e);
        cred[m_win]++;
        ptr = (m_win + 1) % 2;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(int n);
    req_valid = 2'b00;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_req(0, 1'b1, rnd128(), 1'b1, 4'd1);
    set_req(1, 1'b1, rnd128(), 1'b0, 4'd2);
    @(posedge clk); @(negedge clk); #1;
    checks++;
    if (req_ready !== 2'b00 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset ctrl: got rdy=%b ov=%b busy=%b want 00 0 0", req_ready, out_valid, busy);
    end
    checks++;
    if (out_f1 !== 55'd0 || out_id !== 1'b0 || out_tag !== 4'd0) begin
      errors++; $display("FAIL reset data: got f1=%h id=%b tag=%h want 0", out_f1, out_id, out_tag);
    end
    step();
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_single();
    logic [127:0] fn = 128'hA1B2C3D4E5F60789ABCDEF0123456789;
    out_ready = 1'b1;
    set_req(0, 1'b1, fn, 1'b1, 4'd3);
    req_valid[1] = 1'b0;
    step();
    req_valid = 2'b00;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL single N+1: got ov=%b busy=%b want 0 1", out_valid, busy);
    end
    step();
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_f1 !== ref_rept(fn, 1'b1) || out_id !== 1'b0 || out_tag !== 4'd3 || busy !== 1'b1) begin
      errors++; $display("FAIL single N+2: got ov=%b f1=%h id=%b tag=%0d want 1 %h 0 3",
                         out_valid, out_f1, out_id, out_tag, ref_rept(fn, 1'b1));
    end
    step();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL single idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_contention();
    logic [1:0] got, prev = 2'b00;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      set_req(0, 1'b1, rnd128(), 1'($urandom), 4'($urandom));
      set_req(1, 1'b1, rnd128(), 1'($urandom), 4'($urandom));
      #1 got = req_ready;
      checks++;
      if (!(got == 2'b01 || got == 2'b10) || got == prev) begin
        errors++; $display("FAIL contention grant: got %b prev %b want alternating one-hot", got, prev);
      end
      prev = got;
      step();
    end
    idle(3);
  endtask

  task automatic test_backpressure();
    int acc = 0;
    logic [54:0] held = '0;
    bit seen = 0;
    out_ready = 1'b0;
    req_valid[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      set_req(0, 1'b1, rnd128(), 1'($urandom), 4'(c + 8));
      #1;
      if (req_ready[0]) acc++;
      if (seen) begin
        checks++;
        if (out_f1 !== held) begin
          errors++; $display("FAIL stall stable: got %h want %h", out_f1, held);
        end
      end
      if (out_valid && !seen) begin seen = 1; held = out_f1; end
      step();
    end
    checks++;
    if (acc != 2) begin
      errors++; $display("FAIL stall accepts: got %0d want 2", acc);
    end
    out_ready = 1'b1;
    idle(4);
  endtask

  task automatic test_credit();
    int acc = 0;
    out_ready = 1'b0;
    req_valid[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_req(1, 1'b1, rnd128(), 1'b1, 4'(c));
      #1;
      if (req_ready[1]) acc++;
      step();
    end
    checks++;
    if (acc != 2) begin
      errors++; $display("FAIL credit accepts: got %0d want 2", acc);
    end
    set_req(0, 1'b1, rnd128(), 1'b0, 4'd7);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (req_ready !== 2'b00) begin
        errors++; $display("FAIL credit full: got %b want 00", req_ready);
      end
      step();
    end
    out_ready = 1'b1;
    idle(4);
  endtask

  task automatic test_flush();
    logic [127:0] fn = 128'h1234567890ABCDEFFEDCBA0987654321;
    out_ready = 1'b0;
    req_valid[1] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      set_req(0, 1'b1, rnd128(), 1'b1, 4'(c));
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    req_valid = 2'b00;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush: got ov=%b busy=%b want 0 0", out_valid, busy);
    end
    out_ready = 1'b1;
    set_req(0, 1'b1, fn, 1'b0, 4'd5);
    step();
    req_valid = 2'b00;
    step();
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_f1 !== ref_rept(fn, 1'b0) || out_tag !== 4'd5) begin
      errors++; $display("FAIL post-flush: got ov=%b f1=%h tag=%0d want 1 %h 5",
                         out_valid, out_f1, out_tag, ref_rept(fn, 1'b0));
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    req_valid[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_req(0, 1'b1, rnd128(), 1'b1, 4'(c));
      step();
    end
    req_valid = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset mid: got ov=%b busy=%b want 0 0", out_valid, busy);
    end
    set_req(0, 1'b1, rnd128(), 1'b0, 4'd9);
    set_req(1, 1'b1, rnd128(), 1'b1, 4'd10);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL reset ptr: got %b want 01", req_ready);
    end
    step();
    out_ready = 1'b1;
    idle(4);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_req(0, 1'($urandom), rnd128(), 1'($urandom), 4'($urandom));
      set_req(1, 1'($urandom), rnd128(), 1'($urandom), 4'($urandom));
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 32) == 0;
      step();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    idle(4);
  endtask

  initial begin
    req_valid = 2'b00; req_fn = '0; req_db = '0; req_tag = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_credit();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
